// File: rtl/bit_serial_addsub_pkg.sv
// bit_serial_addsub_pkg: shared state encoding and counter sizing for the serial add/subtract unit
package bit_serial_addsub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/bit_serial_addsub_fa.sv
// serial_fa_cell: one-bit full adder with a loadable carry flop
module serial_fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_en,
  output logic o_s,
  output logic o_c_next,
  output logic o_carry
);
  always_comb begin
    o_s      = i_a ^ i_b ^ o_carry;
    o_c_next = (i_a & i_b) | (i_a & o_carry) | (i_b & o_carry);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_carry <= 1'b0;
    else if (i_load) o_carry <= i_load_val;
    else if (i_en) o_carry <= o_c_next;
endmodule

// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub: WIDTH-bit LSB-first serial add/subtract with start/busy/done handshake
module bit_serial_addsub
  import bit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_ss;
  logic [CW-1:0] r_cnt;
  logic r_cmsb, w_start, w_shift, w_last, w_s, w_c, w_carry;
  serial_fa_cell u_fa (
    .clk       (clk),
    .rst_n     (reset),
    .i_a       (r_sa[0]),
    .i_b       (r_sb[0]),
    .i_load    (w_start),
    .i_load_val(sub),
    .i_en      (w_shift),
    .o_s       (w_s),
    .o_c_next  (w_c),
    .o_carry   (w_carry)
  );
  always_comb begin
    w_shift = r_state == ST_SHIFT;
    w_start = !clr && start && !w_shift;
    w_last  = w_shift && r_cnt == CW'(WIDTH-1);
    w_next  = clr ? ST_IDLE : w_start ? ST_SHIFT : w_shift ? (w_last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    busy    = w_shift;
    done    = r_state == ST_DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  // carry into the MSB is captured one bit early so overflow is ready at the last edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_ss     <= '0;
      r_cnt    <= '0;
      r_cmsb   <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (w_start) begin
      r_sa  <= a;
      r_sb  <= sub ? ~b : b;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_ss  <= {w_s, r_ss[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH-2)) r_cmsb <= w_c;
      if (w_last) begin
        sum      <= {w_s, r_ss[WIDTH-1:1]};
        cout     <= w_c;
        overflow <= r_cmsb ^ w_c;
      end
    end
endmodule
